periph_read_arbiter: RTL and testbench

- Parametrised, registered read-data selector between the CPU's data-memory read port and NCH memory-mapped peripheral channels.
- Successor to the fixed six-source combinational read mux.
- Decodes a peripheral window by address and returns data one cycle after the read strobe, with a valid flag.
- Provides per-channel sticky event capture with clear-on-read, so short button and encoder pulses are not missed between polls.

---
 rtl/periph_read_arbiter.sv | 162 ++++++++++++++++
 tb/tb_periph_read_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_read_arbiter.sv
// -----------------------------------------------------------------------------
// periph_read_arbiter
//
// Registered read-data selector between the CPU data-memory read port and NCH
// memory-mapped peripheral channels. A read strobed at one clock edge returns
// its data, a valid pulse and a peripheral-hit flag at the next edge. Reads can
// be issued every cycle.
//
// Channels flagged in STICKY_MASK are event channels: every bit that goes high
// on the channel input is OR-accumulated into a sticky register. A read returns
// the accumulated bits together with the bits present in the read cycle, and
// clears the register in the same edge. This way short pulses, such as button
// presses, are caught even when they fall between polls.
//
// Optional build macro: PERIPH_READ_ERR_EN
//   defined   : accesses with addr[11]=1 that do not decode to a channel
//               (unmapped or misaligned) return 32'hDEAD_BEEF and pulse err.
//   undefined : those accesses return dmem_rdata (legacy behaviour), and the
//               err port does not exist.
//
// Parameters
//   NCH          number of peripheral channels (1..16)
//   BASE         byte offset of channel 0 in addr[11:0]; bit 11 set, [1:0] clear
//   STICKY_MASK  bit i set = channel i is a sticky event channel
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   addr         CPU data byte address, sampled when rd_en=1
//   rd_en        read strobe, one cycle per read
//   dmem_rdata   data-memory read data for addr, valid together with rd_en
//   ch_data      peripheral inputs, channel i at bits [32*i+31:32*i]
//   rdata        registered read data (holds between reads)
//   rdata_valid  one-cycle pulse, rdata valid
//   periph_hit   registered, 1 when the returned read came from a channel
//   err          (PERIPH_READ_ERR_EN only) one-cycle pulse with rdata_valid
//                for an unmapped or misaligned access in the peripheral half
// -----------------------------------------------------------------------------
module periph_read_arbiter #(
   parameter int             NCH         = 8,
   parameter logic [11:0]    BASE        = 12'h808,
   parameter logic [NCH-1:0] STICKY_MASK = NCH'('h04)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic              rd_en,
   input  logic [31:0]       dmem_rdata,
   input  logic [NCH*32-1:0] ch_data,
   output logic [31:0]       rdata,
   output logic              rdata_valid,
`ifdef PERIPH_READ_ERR_EN
   output logic              periph_hit,
   output logic              err
`else
   output logic              periph_hit
`endif
);

   // One past the last byte of the channel window, computed one bit wider so a
   // window ending exactly at 12'hFFF+1 does not wrap.
   localparam logic [12:0] WIN_END = 13'(BASE) + 13'(4 * NCH);

   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   // ---------------------------------------------------------------- stage p0
   logic [9:0]     word_rel_p0;
   logic           hit_p0;
   logic [NCH-1:0] sel_p0;
   logic [31:0]    rd_val_p0;
   logic [31:0]    sticky [NCH];
`ifdef PERIPH_READ_ERR_EN
   logic           err_p0;
`endif

   // addr[31:12] take no part in the decode.
   logic unused_upper_addr;
   assign unused_upper_addr = ^addr[31:12];

   // Word offset from channel 0; only meaningful when the access is aligned.
   assign word_rel_p0 = addr[11:2] - BASE[11:2];

   always_comb begin
      hit_p0 = addr[11] && (addr[1:0] == 2'b00) &&
               (addr[11:0] >= BASE) && ({1'b0, addr[11:0]} < WIN_END);
      sel_p0 = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_p0[i] = hit_p0 && (word_rel_p0 == 10'(i));
      end
   end

   // Read-data select. A sticky channel returns the accumulated events plus
   // whatever is on the input in the read cycle, so nothing raised during the
   // clearing edge is lost.
   always_comb begin
      rd_val_p0 = dmem_rdata;
      for (int i = 0; i < NCH; i++) begin
         if (sel_p0[i]) begin
            if (STICKY_MASK[i]) begin
               rd_val_p0 = sticky[i] | ch_data[32*i +: 32];
            end else begin
               rd_val_p0 = ch_data[32*i +: 32];
            end
         end
      end
`ifdef PERIPH_READ_ERR_EN
      err_p0 = addr[11] && !hit_p0;
      if (err_p0) begin
         rd_val_p0 = ERR_WORD;
      end
`endif
   end

   // Sticky event registers. Non-sticky channels keep a constant zero register
   // that synthesis removes. A read of a channel clears only that channel.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst || !STICKY_MASK[i] || (rd_en && sel_p0[i])) begin
            sticky[i] <= '0;
         end else begin
            sticky[i] <= sticky[i] | ch_data[32*i +: 32];
         end
      end
   end

   // ---------------------------------------------------------------- stage p1
   logic [31:0] rdata_p1;
   logic        vld_p1;
   logic        hit_p1;
`ifdef PERIPH_READ_ERR_EN
   logic        err_p1;
`endif

   // rdata holds its value between reads; the flags are single-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_p1 <= '0;
         vld_p1   <= 1'b0;
         hit_p1   <= 1'b0;
`ifdef PERIPH_READ_ERR_EN
         err_p1   <= 1'b0;
`endif
      end else begin
         vld_p1 <= rd_en;
         hit_p1 <= rd_en && hit_p0;
`ifdef PERIPH_READ_ERR_EN
         err_p1 <= rd_en && err_p0;
`endif
         if (rd_en) begin
            rdata_p1 <= rd_val_p0;
         end
      end
   end

   assign rdata       = rdata_p1;
   assign rdata_valid = vld_p1;
   assign periph_hit  = hit_p1;
`ifdef PERIPH_READ_ERR_EN
   assign err         = err_p1;
`endif

endmodule

// File: tb/tb_periph_read_arbiter.sv
module tb_periph_read_arbiter;

   localparam int          NCH    = 8;
   localparam logic [11:0] BASE   = 12'h808;
   localparam logic [7:0]  STICKY = 8'h04;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       addr;
   logic              rd_en;
   logic [31:0]       dmem_rdata;
   logic [NCH*32-1:0] ch_data;
   logic [31:0]       rdata;
   logic              rdata_valid;
   logic              periph_hit;
`ifdef PERIPH_READ_ERR_EN
   logic              err;
`endif

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: accumulated events per channel and expected outputs.
   logic [31:0] acc [NCH];
   logic [31:0] exp_rdata;
   logic        exp_vld;
   logic        exp_hit;
   logic        exp_err;

   always #5 clk = ~clk;

   periph_read_arbiter #(
      .NCH(NCH), .BASE(BASE), .STICKY_MASK(STICKY)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en),
      .dmem_rdata(dmem_rdata), .ch_data(ch_data),
      .rdata(rdata), .rdata_valid(rdata_valid),
`ifdef PERIPH_READ_ERR_EN
      .periph_hit(periph_hit), .err(err)
`else
      .periph_hit(periph_hit)
`endif
   );

   function automatic bit err_build();
`ifdef PERIPH_READ_ERR_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ch_get(int i);
      return ch_data[32*i +: 32];
   endfunction

   task automatic ch_set(int i, logic [31:0] v);
      ch_data[32*i +: 32] = v;
   endtask

   // Applies the register-transfer rules of the block to the inputs present
   // before the coming edge, using plain integer address arithmetic.
   task automatic model_edge();
      int off, idx;
      bit hit;
      logic [31:0] val;
      if (rst) begin
         exp_rdata = 32'h0; exp_vld = 1'b0; exp_hit = 1'b0; exp_err = 1'b0;
         for (int i = 0; i < NCH; i++) acc[i] = 32'h0;
         return;
      end
      off = int'(addr[11:0]);
      hit = addr[11] && (off % 4 == 0) && off >= int'(BASE) && off < int'(BASE) + 4 * NCH;
      idx = hit ? (off - int'(BASE)) / 4 : -1;
      exp_vld = rd_en;
      exp_hit = rd_en && hit;
      exp_err = rd_en && !hit && addr[11] && err_build();
      if (rd_en) begin
         if (hit) val = STICKY[idx] ? (acc[idx] | ch_get(idx)) : ch_get(idx);
         else if (addr[11] && err_build()) val = 32'hDEAD_BEEF;
         else val = dmem_rdata;
         exp_rdata = val;
      end
      for (int i = 0; i < NCH; i++) begin
         if (!STICKY[i] || (rd_en && i == idx)) acc[i] = 32'h0;
         else acc[i] = acc[i] | ch_get(i);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_en = 1'b1; addr = 32'h0000_0810; dmem_rdata = 32'h5555_AAAA;
      for (int i = 0; i < NCH; i++) ch_set(i, 32'hFF00_0000 | i);
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++;
         if (rdata !== 32'h0 || rdata_valid !== 1'b0 || periph_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_c%0d: rdata=%h valid=%b hit=%b, want 0/0/0", c, rdata, rdata_valid, periph_hit);
         end
      end
      rst = 1'b0;
      ch_data = '0;
      ch_set(2, 32'h0000_0010);
      tick();
      vectors++;
      if (rdata !== 32'h0000_0010 || rdata_valid !== 1'b1 || periph_hit !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_first_ch2: rdata=%h valid=%b hit=%b, want 00000010/1/1", rdata, rdata_valid, periph_hit);
      end
      rd_en = 1'b0; ch_data = '0;
      tick();
      vectors++;
      if (rdata !== 32'h0000_0010 || rdata_valid !== 1'b0 || periph_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: rdata=%h valid=%b hit=%b, want 00000010/0/0", rdata, rdata_valid, periph_hit);
      end
   endtask

   task automatic test_plain_channel();
      ch_set(0, 32'h1234_5678);
      rd_en = 1'b1; addr = 32'h0000_0808;
      tick();
      vectors++;
      if (rdata !== 32'h1234_5678 || rdata_valid !== 1'b1 || periph_hit !== 1'b1) begin
         miscompares++;
         $display("FAIL plain_ch0: rdata=%h valid=%b hit=%b, want 12345678/1/1", rdata, rdata_valid, periph_hit);
      end
      addr = 32'h1000_0808;
      tick();
      vectors++;
      if (rdata !== 32'h1234_5678 || periph_hit !== 1'b1) begin
         miscompares++;
         $display("FAIL plain_upper_ignored: rdata=%h hit=%b, want 12345678/1", rdata, periph_hit);
      end
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_dmem_path();
      rd_en = 1'b1; addr = 32'h0000_0400; dmem_rdata = 32'hCAFE_0001;
      tick();
      vectors++;
      if (rdata !== 32'hCAFE_0001 || rdata_valid !== 1'b1 || periph_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL dmem_400: rdata=%h valid=%b hit=%b, want CAFE0001/1/0", rdata, rdata_valid, periph_hit);
      end
      addr = 32'h0000_080A; dmem_rdata = 32'hCAFE_0002;
      tick();
      vectors++;
`ifdef PERIPH_READ_ERR_EN
      if (rdata !== 32'hDEAD_BEEF || err !== 1'b1 || periph_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL misaligned_err: rdata=%h err=%b hit=%b, want DEADBEEF/1/0", rdata, err, periph_hit);
      end
`else
      if (rdata !== 32'hCAFE_0002 || periph_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL misaligned_dmem: rdata=%h hit=%b, want CAFE0002/0", rdata, periph_hit);
      end
`endif
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_sticky_capture();
      ch_data = '0; rd_en = 1'b0;
      ch_set(2, 32'h1);
      tick();
      ch_set(2, 32'h0);
      tick();
      for (int i = 0; i < 5; i++) tick();
      rd_en = 1'b1; addr = 32'h0000_0810;
      tick();
      vectors++;
      if (rdata !== 32'h1 || periph_hit !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_capture: rdata=%h hit=%b, want 00000001/1", rdata, periph_hit);
      end
      tick();
      vectors++;
      if (rdata !== 32'h0 || rdata_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_cleared: rdata=%h valid=%b, want 00000000/1", rdata, rdata_valid);
      end
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_sticky_simultaneous();
      rd_en = 1'b0; ch_set(2, 32'h1);
      tick();
      ch_set(2, 32'h2); rd_en = 1'b1; addr = 32'h0000_0810;
      tick();
      vectors++;
      if (rdata !== 32'h3) begin
         miscompares++;
         $display("FAIL sticky_simul: rdata=%h, want 00000003", rdata);
      end
      ch_set(2, 32'h4); rd_en = 1'b0;
      tick();
      ch_set(2, 32'h0); rd_en = 1'b1;
      tick();
      vectors++;
      if (rdata !== 32'h4) begin
         miscompares++;
         $display("FAIL sticky_after_read: rdata=%h, want 00000004", rdata);
      end
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] want [3];
      logic [31:0] a [3];
      logic        want_hit [3];
      want[0] = 32'hA0A0_0000; want[1] = 32'hB1B1_1111; want[2] = 32'hD0D0_4444;
      a[0] = 32'h808; a[1] = 32'h80C; a[2] = 32'h400;
      want_hit[0] = 1'b1; want_hit[1] = 1'b1; want_hit[2] = 1'b0;
      ch_set(0, want[0]); ch_set(1, want[1]); dmem_rdata = want[2];
      rd_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr = a[k];
         tick();
         vectors++;
         if (rdata !== want[k] || rdata_valid !== 1'b1 || periph_hit !== want_hit[k]) begin
            miscompares++;
            $display("FAIL b2b_%0d: rdata=%h valid=%b hit=%b, want %h/1/%b",
                     k, rdata, rdata_valid, periph_hit, want[k], want_hit[k]);
         end
      end
      rd_en = 1'b0;
      tick();
      vectors++;
      if (rdata_valid !== 1'b0 || rdata !== want[2]) begin
         miscompares++;
         $display("FAIL b2b_end: rdata=%h valid=%b, want %h/0", rdata, rdata_valid, want[2]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 59) == 0);
         rd_en = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: addr = {$urandom_range(0, 32'hFFFFF), 12'(12'h808 + 4 * $urandom_range(0, 9))};
            1: addr = {20'h0, 12'(12'h808 + $urandom_range(0, 40))};
            2: addr = {$urandom_range(0, 32'hFFFFF), 1'b0, 11'($urandom)};
            default: addr = $urandom;
         endcase
         dmem_rdata = $urandom;
         for (int i = 0; i < NCH; i++) begin
            if (STICKY[i]) ch_set(i, ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
            else ch_set(i, $urandom);
         end
         tick();
         vectors++;
         if (rdata !== exp_rdata || rdata_valid !== exp_vld || periph_hit !== exp_hit) begin
            miscompares++;
            $display("FAIL random_%0d: rdata=%h valid=%b hit=%b, want %h/%b/%b",
                     n, rdata, rdata_valid, periph_hit, exp_rdata, exp_vld, exp_hit);
         end
`ifdef PERIPH_READ_ERR_EN
         vectors++;
         if (err !== exp_err) begin
            miscompares++;
            $display("FAIL random_err_%0d: err=%b, want %b", n, err, exp_err);
         end
`endif
      end
      rst = 1'b0; rd_en = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; rd_en = 1'b0; addr = '0; dmem_rdata = '0; ch_data = '0;
      for (int i = 0; i < NCH; i++) acc[i] = 32'h0;
      exp_rdata = '0; exp_vld = 1'b0; exp_hit = 1'b0; exp_err = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_plain_channel();
      test_dmem_path();
      test_sticky_capture();
      test_sticky_simultaneous();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
